sram_ctrl: RTL and testbench
============================

SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 The block SHALL have parameter WAIT_CYCLES, default 2: strobe-active cycles per access, legal range 1..15.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port req, input, 1 bit: the client requests an access.
REQ-005 The block SHALL have port rd, input, 1 bit: 1 selects read, 0 selects write; qualified by req.
REQ-006 The block SHALL have port be, input, 2 bits: byte enables; bit 0 is the low byte, bit 1 the high byte.
REQ-007 The block SHALL have port addr, input, 18 bits: word address.
REQ-008 The block SHALL have port wr_data, input, 16 bits: write data.
REQ-009 The block SHALL have port ready, output, 1 bit: the controller can accept a request this cycle.
REQ-010 The block SHALL have port rd_data, output, 16 bits: captured read data.
REQ-011 The block SHALL have port rd_data_vld, output, 1 bit: one-cycle strobe marking rd_data valid.
REQ-012 The block SHALL have port sram_a, output, 18 bits: external address.
REQ-013 The block SHALL have ports sram_dq_o (output, 16 bits), sram_dq_oe (output, 1 bit) and sram_dq_i (input, 16 bits): the split tristate data bus; the tristate buffer is instantiated at top level.
REQ-014 The block SHALL have ports sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n and sram_ub_n, each output, 1 bit, active-low: the external strobes.

Function
REQ-015 An access SHALL be accepted in any cycle where req && ready; addr, be, wr_data and rd SHALL be latched in that cycle.
REQ-016 ready SHALL be 1 only in state IDLE; req while ready=0 SHALL be ignored, with no queuing.
REQ-017 The FSM SHALL have states IDLE, RD, WR, WR_HOLD and TURN, where TURN exists only under REQ-031.
REQ-018 Transitions SHALL be: IDLE->RD on an accepted read; IDLE->WR on an accepted write; RD->IDLE after WAIT_CYCLES cycles; WR->WR_HOLD after WAIT_CYCLES cycles; WR_HOLD->IDLE after 1 cycle.
REQ-019 A 4-bit wait counter SHALL load WAIT_CYCLES-1 on acceptance and decrement in RD/WR; the state SHALL exit when the counter is 0.
REQ-020 In RD: sram_ce_n=0, sram_oe_n=0, sram_we_n=1, sram_dq_oe=0, and lb_n/ub_n equal to ~latched be.
REQ-021 In WR: sram_ce_n=0, sram_we_n=0, sram_oe_n=1, sram_dq_oe=1, sram_dq_o equal to latched data, and lb_n/ub_n equal to ~latched be.
REQ-022 In WR_HOLD: sram_we_n=1 and ce_n=1, with sram_a, sram_dq_o and sram_dq_oe=1 held, giving address/data hold after the WE rising edge.
REQ-023 In IDLE and TURN: all strobes SHALL be 1 and sram_dq_oe=0; sram_a SHALL hold the last latched address.
REQ-024 sram_a SHALL be stable for the whole RD, WR and WR_HOLD dwell.
REQ-025 Read latency: for acceptance at edge T, sram_dq_i SHALL be registered into rd_data at edge T+WAIT_CYCLES, and rd_data_vld=1 for exactly the following cycle, concurrent with ready=1.
REQ-026 rd_data SHALL hold its value until the next read capture; rd_data_vld SHALL never assert for writes.
REQ-027 Write occupancy: for acceptance at edge T, ready SHALL be 1 again after edge T+WAIT_CYCLES+1.
REQ-028 Back-to-back: a request presented in the cycle ready returns SHALL be accepted, so there are no dead cycles except TURN.
REQ-029 be=2'b00 SHALL still run a full access with both lb_n and ub_n high; any read data returned for it is don't-care.

Reset
REQ-030 While rst=1, immediately and asynchronously: state=IDLE, counter=0, ready=1, rd_data=0, rd_data_vld=0, sram_a=0, sram_dq_o=0, sram_dq_oe=0, all strobes=1; an access aborted mid-cycle SHALL be dropped with no completion strobe.

Configuration
REQ-031 With macro SRAM_CTRL_TURNAROUND_EN defined, a RD completion followed by an accepted write SHALL pass through one TURN cycle (bus released) before WR, and that write's occupancy SHALL grow by 1; without the macro, the TURN state SHALL not exist and IDLE->WR SHALL be direct.

Verification
REQ-032 The bench SHALL drive reset pulsed mid-WR (we_n=0) and check that we_n, ce_n and dq_oe return to 1/1/0 within the same cycle with no clock.
REQ-033 The bench SHALL run WAIT_CYCLES=2: write addr=18'h00005, data=16'hA55A, be=2'b11, then read addr 18'h00005 with an SRAM model; rd_data=16'hA55A and rd_data_vld high for 1 cycle, 3 cycles after acceptance.
REQ-034 The bench SHALL write be=2'b01 with data 16'h1234 to a location holding 16'hFFFF; a read back SHALL return 16'hFF34, and ub_n SHALL stay 1 throughout the write.
REQ-035 The bench SHALL hold req=1 continuously for 4 reads; acceptances SHALL be spaced WAIT_CYCLES+1 cycles apart, and addresses 0..3 SHALL be returned in order.
REQ-036 The bench SHALL issue a read immediately followed by a write, with and without SRAM_CTRL_TURNAROUND_EN; dq_oe=1 SHALL never coincide with oe_n=0, and write acceptance SHALL differ by 1 cycle between builds.

Source files
------------

// File: rtl/sram_ctrl.sv
// sram_ctrl: asynchronous SRAM controller with fixed strobe wait states; optional read-to-write bus turnaround via SRAM_CTRL_TURNAROUND_EN
module sram_ctrl #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        rd,
    input  logic [1:0]  be,
    input  logic [17:0] addr,
    input  logic [15:0] wr_data,
    output logic        ready,
    output logic [15:0] rd_data,
    output logic        rd_data_vld,
    output logic [17:0] sram_a,
    output logic [15:0] sram_dq_o,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_i,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic        sram_lb_n,
    output logic        sram_ub_n
);
`ifdef SRAM_CTRL_TURNAROUND_EN
    typedef enum logic [2:0] {IDLE, RD, WR, WR_HOLD, TURN} state_t;
`else
    typedef enum logic [2:0] {IDLE, RD, WR, WR_HOLD} state_t;
`endif
    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);
    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        ready_q;
    logic [15:0] rd_data_q;
    logic        vld_q;
    logic [17:0] a_q;
    logic [15:0] dq_o_q;
    logic        dq_oe_q;
    logic        ce_n_q;
    logic        oe_n_q;
    logic        we_n_q;
    logic        lb_n_q;
    logic        ub_n_q;
`ifdef SRAM_CTRL_TURNAROUND_EN
    logic [1:0]  be_q;
    logic        after_rd_q;
`endif
    assign ready       = ready_q;
    assign rd_data     = rd_data_q;
    assign rd_data_vld = vld_q;
    assign sram_a      = a_q;
    assign sram_dq_o   = dq_o_q;
    assign sram_dq_oe  = dq_oe_q;
    assign sram_ce_n   = ce_n_q;
    assign sram_oe_n   = oe_n_q;
    assign sram_we_n   = we_n_q;
    assign sram_lb_n   = lb_n_q;
    assign sram_ub_n   = ub_n_q;
    // Access FSM; every pin is registered so strobes change only on clock edges
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            ready_q   <= 1'b1;
            rd_data_q <= 16'd0;
            vld_q     <= 1'b0;
            a_q       <= 18'd0;
            dq_o_q    <= 16'd0;
            dq_oe_q   <= 1'b0;
            ce_n_q    <= 1'b1;
            oe_n_q    <= 1'b1;
            we_n_q    <= 1'b1;
            lb_n_q    <= 1'b1;
            ub_n_q    <= 1'b1;
`ifdef SRAM_CTRL_TURNAROUND_EN
            be_q       <= 2'b00;
            after_rd_q <= 1'b0;
`endif
        end else begin
            vld_q <= 1'b0;
`ifdef SRAM_CTRL_TURNAROUND_EN
            after_rd_q <= 1'b0;
`endif
            case (state_q)
                IDLE: if (req) begin
                    cnt_q   <= CNT_INIT;
                    a_q     <= addr;
                    dq_o_q  <= wr_data;
                    ready_q <= 1'b0;
`ifdef SRAM_CTRL_TURNAROUND_EN
                    be_q    <= be;
`endif
                    if (rd) begin
                        state_q <= RD;
                        ce_n_q  <= 1'b0;
                        oe_n_q  <= 1'b0;
                        lb_n_q  <= ~be[0];
                        ub_n_q  <= ~be[1];
                    end
`ifdef SRAM_CTRL_TURNAROUND_EN
                    else if (after_rd_q) begin
                        state_q <= TURN;
                    end
`endif
                    else begin
                        state_q <= WR;
                        ce_n_q  <= 1'b0;
                        we_n_q  <= 1'b0;
                        dq_oe_q <= 1'b1;
                        lb_n_q  <= ~be[0];
                        ub_n_q  <= ~be[1];
                    end
                end
                RD: if (cnt_q == 4'd0) begin
                    state_q   <= IDLE;
                    ce_n_q    <= 1'b1;
                    oe_n_q    <= 1'b1;
                    lb_n_q    <= 1'b1;
                    ub_n_q    <= 1'b1;
                    ready_q   <= 1'b1;
                    rd_data_q <= sram_dq_i;
                    vld_q     <= 1'b1;
`ifdef SRAM_CTRL_TURNAROUND_EN
                    after_rd_q <= 1'b1;
`endif
                end else begin
                    cnt_q <= cnt_q - 4'd1;
                end
                WR: if (cnt_q == 4'd0) begin
                    state_q <= WR_HOLD;
                    ce_n_q  <= 1'b1;
                    we_n_q  <= 1'b1;
                    lb_n_q  <= 1'b1;
                    ub_n_q  <= 1'b1;
                end else begin
                    cnt_q <= cnt_q - 4'd1;
                end
                WR_HOLD: begin
                    state_q <= IDLE;
                    dq_oe_q <= 1'b0;
                    ready_q <= 1'b1;
                end
`ifdef SRAM_CTRL_TURNAROUND_EN
                TURN: begin
                    state_q <= WR;
                    ce_n_q  <= 1'b0;
                    we_n_q  <= 1'b0;
                    dq_oe_q <= 1'b1;
                    lb_n_q  <= ~be_q[0];
                    ub_n_q  <= ~be_q[1];
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: randomized scoreboard bench for sram_ctrl with a behavioural SRAM and reference memory
module tb_sram_ctrl;
    localparam int W = 2;
`ifdef SRAM_CTRL_TURNAROUND_EN
    localparam int TURN_EN = 1;
`else
    localparam int TURN_EN = 0;
`endif
    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        rd;
    logic [1:0]  be;
    logic [17:0] addr;
    logic [15:0] wr_data;
    logic        ready;
    logic [15:0] rd_data;
    logic        rd_data_vld;
    logic [17:0] sram_a;
    logic [15:0] sram_dq_o;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_i;
    logic        sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n;
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int busy_until = 0;
    bit last_rd = 1'b0;
    typedef struct {
        logic [15:0] data;
        bit          care;
        int          at;
    } exp_t;
    exp_t exp_q[$];
    logic [15:0] mem [0:1023];
    logic [15:0] ref_mem [0:1023];

    sram_ctrl #(.WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst), .req(req), .rd(rd), .be(be), .addr(addr),
        .wr_data(wr_data), .ready(ready), .rd_data(rd_data), .rd_data_vld(rd_data_vld),
        .sram_a(sram_a), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe), .sram_dq_i(sram_dq_i),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
        .sram_lb_n(sram_lb_n), .sram_ub_n(sram_ub_n)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] pat(int i);
        return 16'((i * 37) ^ 16'h5A00);
    endfunction

    function automatic void check(string nm, int act, int expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, expv, cyc);
        end
    endfunction

    // Behavioural asynchronous SRAM with byte lanes
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 1024; i++) mem[i] <= pat(i);
        end else if (!sram_ce_n && !sram_we_n) begin
            if (!sram_lb_n) mem[sram_a[9:0]][7:0] <= sram_dq_o[7:0];
            if (!sram_ub_n) mem[sram_a[9:0]][15:8] <= sram_dq_o[15:8];
        end
    end
    assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_a[9:0]] : 16'hDEAD;

    // Monitor: pops the scoreboard on each read strobe and watches for bus contention
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (rd_data_vld) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_vld", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("vld_cycle", cyc, e.at);
                    if (e.care) check("rd_data", int'(rd_data), int'(e.data));
                end
            end
            if (sram_dq_oe && !sram_oe_n) check("bus_conflict", 1, 0);
        end
    end

    task automatic issue(input bit r, input logic [1:0] b, input logic [17:0] a, input logic [15:0] d);
        int start, acc, n;
        bit turn;
        req = 1'b1;
        rd = r;
        be = b;
        addr = a;
        wr_data = d;
        start = cyc;
        n = 0;
        while (!ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            check("accept_timeout", 0, 1);
            req = 1'b0;
            return;
        end
        acc = cyc + 1;
        check("accept_edge", acc, ((start > busy_until) ? start : busy_until) + 1);
        turn = (TURN_EN != 0) && last_rd && (acc == busy_until + 1);
        if (r) begin
            exp_q.push_back('{data: ref_mem[a[9:0]], care: (b != 2'b00), at: acc + W});
            busy_until = acc + W;
        end else begin
            if (b[0]) ref_mem[a[9:0]][7:0] = d[7:0];
            if (b[1]) ref_mem[a[9:0]][15:8] = d[15:8];
            busy_until = acc + W + 1 + int'(turn);
        end
        last_rd = r;
        @(negedge clk);
        check("sram_a", int'(sram_a), int'(a));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = pat(i);
        rst = 1'b1;
        req = 1'b0;
        rd = 1'b0;
        be = 2'b00;
        addr = 18'd0;
        wr_data = 16'd0;
        #1;
        check("rst_ready", int'(ready), 1);
        check("rst_vld", int'(rd_data_vld), 0);
        check("rst_rd_data", int'(rd_data), 0);
        check("rst_strobes", int'({sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n}), 5'b11111);
        check("rst_dq_oe", int'(sram_dq_oe), 0);
        check("rst_a", int'(sram_a), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        busy_until = cyc;
        @(negedge clk);
        // write then read back a full word
        issue(1'b0, 2'b11, 18'h00005, 16'hA55A);
        req = 1'b0;
        issue(1'b1, 2'b11, 18'h00005, 16'h0000);
        req = 1'b0;
        // low-byte-only write over an all-ones word, upper lane must stay idle
        issue(1'b0, 2'b11, 18'h00007, 16'hFFFF);
        req = 1'b0;
        issue(1'b0, 2'b01, 18'h00007, 16'h1234);
        req = 1'b0;
        for (int i = 0; i <= W; i++) begin
            check("ub_n_idle", int'(sram_ub_n), 1);
            @(negedge clk);
        end
        issue(1'b1, 2'b11, 18'h00007, 16'h0000);
        req = 1'b0;
        // four reads with req held continuously
        for (int i = 0; i < 4; i++) issue(1'b1, 2'b11, 18'(i), 16'h0000);
        // read immediately followed by write, then a read that exposes the write occupancy
        issue(1'b1, 2'b11, 18'h0000A, 16'h0000);
        issue(1'b0, 2'b11, 18'h0000B, 16'hBEEF);
        issue(1'b1, 2'b11, 18'h0000B, 16'h0000);
        req = 1'b0;
        repeat (2) @(negedge clk);
        // randomized traffic
        for (int k = 0; k < 60; k++) begin
            int gap;
            gap = $urandom_range(0, 2);
            if (gap > 0) begin
                req = 1'b0;
                repeat (gap) @(negedge clk);
            end
            issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 18'($urandom_range(0, 511)), 16'($urandom()));
        end
        req = 1'b0;
        repeat (W + 6) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        // asynchronous reset pulse in the middle of a write
        issue(1'b0, 2'b11, 18'd1000, 16'h0F0F);
        req = 1'b0;
        check("mid_wr_we_n", int'(sram_we_n), 0);
        #2 rst = 1'b1;
        #1;
        check("async_we_n", int'(sram_we_n), 1);
        check("async_ce_n", int'(sram_ce_n), 1);
        check("async_dq_oe", int'(sram_dq_oe), 0);
        check("async_ready", int'(ready), 1);
        #1 rst = 1'b0;
        @(negedge clk);
        busy_until = cyc;
        last_rd = 1'b0;
        repeat (W + 3) begin
            check("post_rst_no_vld", int'(rd_data_vld), 0);
            @(negedge clk);
        end
        issue(1'b1, 2'b11, 18'h00005, 16'h0000);
        req = 1'b0;
        repeat (W + 4) @(negedge clk);
        check("final_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
